// File: rtl/ntt_pkg.sv
// Shared constants, state encoding and modular-arithmetic helpers for the
// forward and inverse NTT cores (N = 256, q = 8380417).
package ntt_pkg;

  localparam int          N_LOG = 8;
  localparam logic [23:0] Q     = 24'd8380417;
  localparam logic [25:0] MU    = 26'd33587228;
  localparam logic [23:0] PSI   = 24'd1753;

  typedef enum logic [4:0] {
    IDLE, PRE_RD, PRE_WAIT, PRE_MUL, PRE_MWAIT, PRE_WR,
    BR_CHECK, BR_RD, BR_WAIT, BR_WR,
    ST_INIT, ST_ROM, LOOP_I, LOOP_J,
    BF_RD, BF_WAIT, BF_MUL, BF_MWAIT, BF_ADD, BF_WR,
    DONE
  } state_t;

  // MU = floor(2^48 / Q), so the quotient estimate is at most two short.
  function automatic logic [23:0] barrett_reduce(input logic [47:0] x);
    logic [73:0] t;
    logic [47:0] qhat;
    logic [47:0] r;
    t    = {26'd0, x} * {48'd0, MU};
    qhat = 48'(t >> 48);
    r    = x - qhat * {24'd0, Q};
    if (r >= {24'd0, Q}) r = r - {24'd0, Q};
    if (r >= {24'd0, Q}) r = r - {24'd0, Q};
    return r[23:0];
  endfunction

  function automatic logic [23:0] mul_q(input logic [23:0] a, input logic [23:0] b);
    return barrett_reduce({24'd0, a} * {24'd0, b});
  endfunction

  function automatic logic [23:0] mod_add(input logic [23:0] a, input logic [23:0] b);
    logic [24:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, Q}) s = s - {1'b0, Q};
    return s[23:0];
  endfunction

  function automatic logic [23:0] mod_sub(input logic [23:0] a, input logic [23:0] b);
    logic [24:0] s;
    s = {1'b0, a} - {1'b0, b};
    if (a < b) s = s + {1'b0, Q};
    return s[23:0];
  endfunction

  function automatic logic [23:0] pow_q(input logic [23:0] b, input int e);
    logic [23:0] acc;
    acc = 24'd1;
    for (int k = 0; k < e; k++) acc = mul_q(acc, b);
    return acc;
  endfunction

  function automatic logic [7:0] bit_reverse(input logic [7:0] x);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = x[7-k];
    return r;
  endfunction

  localparam logic [23:0] OMEGA = mul_q(PSI, PSI);

endpackage

// File: rtl/ntt_core_rom.sv
// Stage twiddle ROM: registered lookup of OMEGA^(128/mid) for mid = 1..128.
module g1_ntt_rom
  import ntt_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  mid,
  output logic [23:0] g1
);

  localparam logic [23:0] G1_1   = pow_q(OMEGA, 128);
  localparam logic [23:0] G1_2   = pow_q(OMEGA, 64);
  localparam logic [23:0] G1_4   = pow_q(OMEGA, 32);
  localparam logic [23:0] G1_8   = pow_q(OMEGA, 16);
  localparam logic [23:0] G1_16  = pow_q(OMEGA, 8);
  localparam logic [23:0] G1_32  = pow_q(OMEGA, 4);
  localparam logic [23:0] G1_64  = pow_q(OMEGA, 2);
  localparam logic [23:0] G1_128 = OMEGA;

  // Registered table lookup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g1 <= 24'd0;
    end else begin
      case (mid)
        9'd1:    g1 <= G1_1;
        9'd2:    g1 <= G1_2;
        9'd4:    g1 <= G1_4;
        9'd8:    g1 <= G1_8;
        9'd16:   g1 <= G1_16;
        9'd32:   g1 <= G1_32;
        9'd64:   g1 <= G1_64;
        9'd128:  g1 <= G1_128;
        default: g1 <= 24'd1;
      endcase
    end
  end

endmodule

// File: rtl/ntt_core.sv
// Forward negacyclic NTT (N = 256): twist by PSI^i, bit-reverse, then eight
// Cooley-Tukey stages, all in place in an external dual-port RAM.
module ntt_core
  import ntt_pkg::*;
#(
  parameter int WIDTH       = 24,
  parameter int MUL_LATENCY = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             done,
  output logic [7:0]       ram_addr_a,
  output logic [7:0]       ram_addr_b,
  output logic             ram_we_a,
  output logic             ram_we_b,
  output logic [WIDTH-1:0] ram_wdata_a,
  output logic [WIDTH-1:0] ram_wdata_b,
  input  logic [WIDTH-1:0] ram_rdata_a,
  input  logic [WIDTH-1:0] ram_rdata_b
);

  state_t      state_r, state_s;
  logic [8:0]  cnt_r, mid_r, i_r, j_r;
  logic [7:0]  rev_s;
  logic [2:0]  wait_r;
  logic [23:0] tw_r, gk_r, gk_next_r, g1_r, u_r, y_r, rom_g1_s;
  logic [23:0] op1a_r, op1b_r, op2a_r, op2b_r, red1_r, red2_r;
  logic [47:0] prod1_r, prod2_r;
  logic [7:0]  addr_a_r, addr_b_r;
  logic        we_a_r, we_b_r, done_r;
  logic [23:0] wdata_a_r, wdata_b_r;

  assign rev_s       = bit_reverse(cnt_r[7:0]);
  assign done        = done_r;
  assign ram_addr_a  = addr_a_r;
  assign ram_addr_b  = addr_b_r;
  assign ram_we_a    = we_a_r;
  assign ram_we_b    = we_b_r;
  assign ram_wdata_a = wdata_a_r;
  assign ram_wdata_b = wdata_b_r;

  g1_ntt_rom u_rom (
    .clk (clk),
    .rst (rst),
    .mid (mid_r),
    .g1  (rom_g1_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:      if (start) state_s = PRE_RD; else state_s = IDLE;
      PRE_RD:    state_s = PRE_WAIT;
      PRE_WAIT:  state_s = PRE_MUL;
      PRE_MUL:   state_s = PRE_MWAIT;
      PRE_MWAIT: if (wait_r == 3'd0) state_s = PRE_WR; else state_s = PRE_MWAIT;
      PRE_WR:    if (cnt_r == 9'd255) state_s = BR_CHECK; else state_s = PRE_RD;
      BR_CHECK: begin
        if (cnt_r[8])                state_s = ST_INIT;
        else if (cnt_r[7:0] < rev_s) state_s = BR_RD;
        else                         state_s = BR_CHECK;
      end
      BR_RD:     state_s = BR_WAIT;
      BR_WAIT:   state_s = BR_WR;
      BR_WR:     state_s = BR_CHECK;
      ST_INIT:   if (mid_r[8]) state_s = DONE; else state_s = ST_ROM;
      ST_ROM:    state_s = LOOP_I;
      LOOP_I:    if (i_r[8]) state_s = ST_INIT; else state_s = LOOP_J;
      LOOP_J:    if (j_r < mid_r) state_s = BF_RD; else state_s = LOOP_I;
      BF_RD:     state_s = BF_WAIT;
      BF_WAIT:   state_s = BF_MUL;
      BF_MUL:    state_s = BF_MWAIT;
      BF_MWAIT:  if (wait_r == 3'd0) state_s = BF_ADD; else state_s = BF_MWAIT;
      BF_ADD:    state_s = BF_WR;
      BF_WR:     state_s = LOOP_J;
      DONE:      if (start) state_s = DONE; else state_s = IDLE;
      default:   state_s = IDLE;
    endcase
  end

  // Two multiplier lanes: product register, then Barrett reduction register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod1_r <= 48'd0;
      prod2_r <= 48'd0;
      red1_r  <= 24'd0;
      red2_r  <= 24'd0;
    end else begin
      prod1_r <= {24'd0, op1a_r} * {24'd0, op1b_r};
      prod2_r <= {24'd0, op2a_r} * {24'd0, op2b_r};
      red1_r  <= barrett_reduce(prod1_r);
      red2_r  <= barrett_reduce(prod2_r);
    end
  end

  // Datapath, loop counters and registered RAM controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= 9'd0;  mid_r <= 9'd0;  i_r <= 9'd0;  j_r <= 9'd0;
      wait_r <= 3'd0;
      tw_r <= 24'd0;  gk_r <= 24'd0;  gk_next_r <= 24'd0;  g1_r <= 24'd0;
      u_r <= 24'd0;   y_r <= 24'd0;
      op1a_r <= 24'd0; op1b_r <= 24'd0; op2a_r <= 24'd0; op2b_r <= 24'd0;
      addr_a_r <= 8'd0; addr_b_r <= 8'd0;
      we_a_r <= 1'b0;   we_b_r <= 1'b0;
      wdata_a_r <= 24'd0; wdata_b_r <= 24'd0;
      done_r <= 1'b0;
    end else begin
      we_a_r <= 1'b0;
      we_b_r <= 1'b0;
      done_r <= (state_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            cnt_r <= 9'd0;
            tw_r  <= 24'd1;
          end
        end
        PRE_RD: addr_a_r <= cnt_r[7:0];
        PRE_MUL: begin
          op1a_r <= ram_rdata_a[23:0];
          op1b_r <= tw_r;
          op2a_r <= tw_r;
          op2b_r <= PSI;
          wait_r <= 3'(MUL_LATENCY);
        end
        PRE_MWAIT: begin
          if (wait_r == 3'd0) begin
            wdata_a_r <= red1_r;
            tw_r      <= red2_r;
          end else begin
            wait_r <= wait_r - 3'd1;
          end
        end
        PRE_WR: begin
          we_a_r <= 1'b1;
          cnt_r  <= (cnt_r == 9'd255) ? 9'd0 : cnt_r + 9'd1;
        end
        BR_CHECK: begin
          if (cnt_r[8])                      mid_r <= 9'd1;
          else if (!(cnt_r[7:0] < rev_s))    cnt_r <= cnt_r + 9'd1;
        end
        BR_RD: begin
          addr_a_r <= cnt_r[7:0];
          addr_b_r <= rev_s;
        end
        BR_WR: begin
          we_a_r    <= 1'b1;
          we_b_r    <= 1'b1;
          wdata_a_r <= ram_rdata_b[23:0];
          wdata_b_r <= ram_rdata_a[23:0];
          cnt_r     <= cnt_r + 9'd1;
        end
        ST_ROM: begin
          g1_r <= rom_g1_s;
          i_r  <= 9'd0;
        end
        LOOP_I: begin
          if (!i_r[8]) begin
            gk_r <= 24'd1;
            j_r  <= 9'd0;
          end else begin
            mid_r <= mid_r << 1;
          end
        end
        LOOP_J: if (!(j_r < mid_r)) i_r <= i_r + (mid_r << 1);
        BF_RD: begin
          addr_a_r <= 8'(i_r + j_r);
          addr_b_r <= 8'(i_r + j_r + mid_r);
        end
        BF_MUL: begin
          u_r    <= ram_rdata_a[23:0];
          op1a_r <= ram_rdata_b[23:0];
          op1b_r <= gk_r;
          op2a_r <= gk_r;
          op2b_r <= g1_r;
          wait_r <= 3'(MUL_LATENCY);
        end
        BF_MWAIT: begin
          if (wait_r == 3'd0) begin
            y_r       <= red1_r;
            gk_next_r <= red2_r;
          end else begin
            wait_r <= wait_r - 3'd1;
          end
        end
        BF_ADD: begin
          wdata_a_r <= mod_add(u_r, y_r);
          wdata_b_r <= mod_sub(u_r, y_r);
        end
        BF_WR: begin
          we_a_r <= 1'b1;
          we_b_r <= 1'b1;
          gk_r   <= gk_next_r;
          j_r    <= j_r + 9'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_core.sv
// Directed bench for ntt_core: behavioural dual-port RAM, delta vectors with
// known transforms, one vector against an O(N^2) negacyclic DFT model.
module tb_ntt_core;

  localparam longint QL = 64'd8380417;

  logic        clk = 1'b0;
  logic        rst, start, done;
  logic [7:0]  ram_addr_a, ram_addr_b;
  logic        ram_we_a, ram_we_b;
  logic [23:0] ram_wdata_a, ram_wdata_b, ram_rdata_a, ram_rdata_b;

  logic [23:0] mem  [0:255];
  logic [23:0] vec  [0:255];
  logic [23:0] expv [0:255];
  logic        ld_we = 1'b0;
  logic [7:0]  ld_addr = 8'd0;
  logic [23:0] ld_data = 24'd0;

  int cyc = 0, wr_cnt = 0, geq_cnt = 0, same_cnt = 0;
  int n_checks = 0, n_pass = 0;
  int c0, c1, c2, wr_snap;

  always #5 clk = ~clk;

  ntt_core dut (
    .clk(clk), .rst(rst), .start(start), .done(done),
    .ram_addr_a(ram_addr_a), .ram_addr_b(ram_addr_b),
    .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
    .ram_wdata_a(ram_wdata_a), .ram_wdata_b(ram_wdata_b),
    .ram_rdata_a(ram_rdata_a), .ram_rdata_b(ram_rdata_b)
  );

  always @(posedge clk) begin
    if (ld_we) begin
      mem[ld_addr] <= ld_data;
    end else begin
      if (ram_we_a) mem[ram_addr_a] <= ram_wdata_a;
      if (ram_we_b) mem[ram_addr_b] <= ram_wdata_b;
    end
    ram_rdata_a <= mem[ram_addr_a];
    ram_rdata_b <= mem[ram_addr_b];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we_a || ram_we_b) wr_cnt <= wr_cnt + 1;
    if ((ram_we_a && longint'(ram_wdata_a) >= QL) || (ram_we_b && longint'(ram_wdata_b) >= QL))
      geq_cnt <= geq_cnt + 1;
    if (ram_we_a && ram_we_b && ram_addr_a == ram_addr_b) same_cnt <= same_cnt + 1;
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic load_vec();
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      ld_we = 1'b1; ld_addr = 8'(k); ld_data = vec[k];
    end
    @(negedge clk);
    ld_we = 1'b0;
  endtask

  task automatic run_ntt(input string tag, output int cycles);
    int s;
    @(negedge clk);
    start = 1'b1;
    s = cyc;
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (done) break;
    end
    cycles = cyc - s;
    check_eq({tag, "_done"}, longint'(done), 1);
  endtask

  task automatic release_start();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic compare_all(input string tag);
    for (int k = 0; k < 256; k++)
      check_eq($sformatf("%s[%0d]", tag, k), longint'(mem[k]), longint'(expv[k]));
  endtask

  task automatic fill(input logic [23:0] a0);
    for (int k = 0; k < 256; k++) begin
      vec[k]  = 24'd0;
      expv[k] = a0;
    end
    vec[0] = a0;
  endtask

  // X_k = sum_i a_i * PSI^(i*(2k+1)) mod Q
  task automatic golden();
    longint pp [0:511];
    longint acc;
    pp[0] = 1;
    for (int e = 1; e < 512; e++) pp[e] = (pp[e-1] * 64'd1753) % QL;
    for (int k = 0; k < 256; k++) begin
      acc = 0;
      for (int i = 0; i < 256; i++)
        acc = (acc + longint'(vec[i]) * pp[(i * (2 * k + 1)) % 512]) % QL;
      expv[k] = acc[23:0];
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_done", longint'(done), 0);
    check_eq("rst_we_a", longint'(ram_we_a), 0);
    check_eq("rst_we_b", longint'(ram_we_b), 0);
    check_eq("rst_addr_a", longint'(ram_addr_a), 0);
    check_eq("rst_wdata_b", longint'(ram_wdata_b), 0);
    rst = 1'b0;

    // all-zero input, then start held high after done
    fill(24'd0);
    load_vec();
    run_ntt("zero", c0);
    compare_all("zero");
    check_eq("cycles_bound", longint'(c0 <= 16500), 1);
    wr_snap = wr_cnt;
    repeat (20) @(negedge clk);
    check_eq("hold_done", longint'(done), 1);
    check_eq("hold_no_writes", longint'(wr_cnt), longint'(wr_snap));
    start = 1'b0;
    @(negedge clk);
    check_eq("done_fall", longint'(done), 0);
    @(negedge clk);

    fill(24'd5);
    load_vec();
    run_ntt("five", c1);
    compare_all("five");
    check_eq("cycles_repeat", longint'(c1), longint'(c0));
    release_start();

    for (int k = 0; k < 256; k++) vec[k] = 24'($urandom_range(8380416, 0));
    vec[3] = 24'd8380416;
    golden();
    load_vec();
    run_ntt("rand", c2);
    compare_all("rand");
    release_start();

    // reset while stage 3 (mid = 4) is running
    for (int k = 0; k < 256; k++) vec[k] = 24'(k * 7919);
    load_vec();
    @(negedge clk);
    start = 1'b1;
    repeat (7000) @(negedge clk);
    #2 rst = 1'b1;
    start = 1'b0;
    #1;
    check_eq("midrst_done", longint'(done), 0);
    check_eq("midrst_we_a", longint'(ram_we_a), 0);
    check_eq("midrst_we_b", longint'(ram_we_b), 0);
    check_eq("midrst_addr_b", longint'(ram_addr_b), 0);
    @(negedge clk);
    rst = 1'b0;
    wr_snap = wr_cnt;
    repeat (10) @(negedge clk);
    check_eq("midrst_idle", longint'(wr_cnt), longint'(wr_snap));

    fill(24'd8380416);
    load_vec();
    run_ntt("qm1", c1);
    compare_all("qm1");
    check_eq("cycles_after_rst", longint'(c1), longint'(c0));
    release_start();

    check_eq("wdata_ge_q", longint'(geq_cnt), 0);
    check_eq("same_addr_wr", longint'(same_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
